// File: rtl/control_fsm_pkg.sv
// Shared definitions for the multi-cycle control FSM and its control decoder:
// 4-bit state codes, 7-bit opcode constants, opcode-class bit positions and
// a small helper that identifies the states in which an instruction retires.
package control_fsm_pkg;

    // State codes are consumed directly by the control decoder, so the
    // numeric values are part of the interface and must not be reordered.
    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADR   = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_EXECUTE_R = 4'd6,
        ST_ALU_WB    = 4'd7,
        ST_EXECUTE_I = 4'd8,
        ST_BNEZ      = 4'd9,
        ST_HALT      = 4'd10
    } state_e;

    // Recognised major opcodes (instr[6:0]).
    localparam logic [6:0] OPC_LW     = 7'b0000011;
    localparam logic [6:0] OPC_SW     = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Bit positions inside the one-hot opcode class vector.
    localparam int CLS_LOAD    = 0;
    localparam int CLS_STORE   = 1;
    localparam int CLS_OP      = 2;
    localparam int CLS_OP_IMM  = 3;
    localparam int CLS_BRANCH  = 4;
    localparam int CLS_ILLEGAL = 5;
    localparam int CLS_W       = 6;

    // States whose exit to FETCH completes (retires) an instruction.
    function automatic logic is_retire_state(input state_e s);
        return (s == ST_MEM_WB) || (s == ST_MEM_WRITE) ||
               (s == ST_ALU_WB) || (s == ST_BNEZ);
    endfunction

endpackage

// File: rtl/control_fsm_opcode_class.sv
// Purely combinational opcode classifier: maps a 7-bit major opcode onto a
// one-hot class vector {illegal, branch, op_imm, op, store, load}.
// Exactly one bit is set for every input value.
module opcode_class
    import control_fsm_pkg::*;
(
    input  logic [6:0]        opcode,
    output logic [CLS_W-1:0]  cls
);

    // Decode the opcode; anything not recognised is flagged illegal.
    always_comb begin
        cls = '0;
        unique case (opcode)
            OPC_LW:     cls[CLS_LOAD]    = 1'b1;
            OPC_SW:     cls[CLS_STORE]   = 1'b1;
            OPC_OP:     cls[CLS_OP]      = 1'b1;
            OPC_OP_IMM: cls[CLS_OP_IMM]  = 1'b1;
            OPC_BRANCH: cls[CLS_BRANCH]  = 1'b1;
            default:    cls[CLS_ILLEGAL] = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle processor control FSM.
//
// Sequences FETCH/DECODE and the per-class execution states, latches the
// opcode in DECODE, counts retired instructions and pulses instr_done once
// per retire.  Compile-time option:
//   MEM_WAIT_EN  - when defined, FETCH, MEM_READ and MEM_WRITE stall until
//                  mem_ready=1; when undefined, mem_ready is ignored and each
//                  memory state lasts exactly one cycle.
module control_fsm
    import control_fsm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic [3:0]  curr_state,
    output logic        branch_taken,
    output logic        instr_done,
    output logic        halted,
    output logic [31:0] retired
);

`ifdef MEM_WAIT_EN
    localparam logic MEM_WAIT = 1'b1;
`else
    localparam logic MEM_WAIT = 1'b0;
`endif

    state_e             state_q, state_d;
    logic [6:0]         opcode_q, opcode_d;
    logic               instr_done_q, instr_done_d;
    logic               halted_q, halted_d;
    logic [31:0]        retired_q, retired_d;

    logic [6:0]         cls_opcode;
    logic [CLS_W-1:0]   cls;
    logic               mem_go;
    logic               retire;

    // With waits disabled the handshake is forced true, so memory states
    // always advance after one cycle.
    assign mem_go = mem_ready | ~MEM_WAIT;

    // DECODE classifies the live opcode; every later state must only see the
    // value captured in DECODE, so the classifier input switches to the latch.
    assign cls_opcode = (state_q == ST_DECODE) ? opcode : opcode_q;

    opcode_class u_opcode_class (
        .opcode (cls_opcode),
        .cls    (cls)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FETCH: begin
                if (mem_go) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (cls[CLS_LOAD] || cls[CLS_STORE]) state_d = ST_MEM_ADR;
                else if (cls[CLS_OP])                state_d = ST_EXECUTE_R;
                else if (cls[CLS_OP_IMM])            state_d = ST_EXECUTE_I;
                else if (cls[CLS_BRANCH])            state_d = ST_BNEZ;
                else                                 state_d = ST_HALT;
            end
            ST_MEM_ADR: begin
                // Only loads and stores reach here; anything else would be a
                // corrupted latch and is treated as fatal.
                if (cls[CLS_LOAD])       state_d = ST_MEM_READ;
                else if (cls[CLS_STORE]) state_d = ST_MEM_WRITE;
                else                     state_d = ST_HALT;
            end
            ST_MEM_READ: begin
                if (mem_go) state_d = ST_MEM_WB;
            end
            ST_MEM_WRITE: begin
                if (mem_go) state_d = ST_FETCH;
            end
            ST_MEM_WB:    state_d = ST_FETCH;
            ST_EXECUTE_R: state_d = ST_ALU_WB;
            ST_EXECUTE_I: state_d = ST_ALU_WB;
            ST_ALU_WB:    state_d = ST_FETCH;
            ST_BNEZ:      state_d = ST_FETCH;
            ST_HALT:      state_d = ST_HALT;
            // Codes 11-15 have no meaning; park the machine.
            default:      state_d = ST_HALT;
        endcase
    end

    // Retire bookkeeping, opcode latch and halted flag for the next cycle.
    always_comb begin
        retire       = is_retire_state(state_q) && (state_d == ST_FETCH);
        opcode_d     = (state_q == ST_DECODE) ? opcode : opcode_q;
        instr_done_d = retire;
        retired_d    = retire ? retired_q + 32'd1 : retired_q;
        halted_d     = (state_d == ST_HALT);
    end

    // State and status registers; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_FETCH;
            opcode_q     <= '0;
            instr_done_q <= 1'b0;
            halted_q     <= 1'b0;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            instr_done_q <= instr_done_d;
            halted_q     <= halted_d;
            retired_q    <= retired_d;
        end
    end

    assign curr_state   = state_q;
    assign branch_taken = (state_q == ST_BNEZ) && !zero;
    assign instr_done   = instr_done_q;
    assign halted       = halted_q;
    assign retired      = retired_q;

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: a per-cycle vector table for the
// ordinary instruction flows plus hand-written multi-cycle corner cases
// (halt, reset in MEM_WB, memory waits, retire counter wrap).
module tb_control_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic [3:0]  curr_state;
    logic        branch_taken;
    logic        instr_done;
    logic        halted;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OPI    = 7'b0010011;
    localparam logic [6:0] BR     = 7'b1100011;
    localparam logic [6:0] BAD    = 7'b1111111;

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic        z;
        logic        mr;
        logic [3:0]  st;
        logic        dn;
        logic        tk;
        logic        hl;
        logic [31:0] ret;
    } vec_t;

    vec_t vecs[$];

    control_fsm dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .curr_state   (curr_state),
        .branch_taken (branch_taken),
        .instr_done   (instr_done),
        .halted       (halted),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs, take one rising edge, then settle just after it.
    task automatic step(input logic r, input logic [6:0] op, input logic z, input logic mr);
        reset     = r;
        opcode    = op;
        zero      = z;
        mem_ready = mr;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic [6:0] op, input logic z, input logic mr,
                       input logic [3:0] st, input logic dn, input logic tk,
                       input logic hl, input logic [31:0] ret);
        vec_t v;
        v.rst = r; v.op = op; v.z = z; v.mr = mr;
        v.st = st; v.dn = dn; v.tk = tk; v.hl = hl; v.ret = ret;
        vecs.push_back(v);
    endtask

    initial begin
        int pulses;
        reset = 1'b1; opcode = '0; zero = 1'b1; mem_ready = 1'b1;

        //   rst op   z  mr  state done taken halt retired
        add(1, 7'd0, 1, 1, 4'd0, 0, 0, 0, 0);   // reset state
        add(0, OPI,  1, 1, 4'd1, 0, 0, 0, 0);   // OP_IMM: 0,1,8,7,0
        add(0, OPI,  1, 1, 4'd8, 0, 0, 0, 0);
        add(0, OPI,  1, 1, 4'd7, 0, 0, 0, 0);
        add(0, OPI,  1, 1, 4'd0, 1, 0, 0, 1);
        add(0, BR,   0, 1, 4'd1, 0, 0, 0, 1);   // BRANCH, zero=0: taken
        add(0, BR,   0, 1, 4'd9, 0, 1, 0, 1);
        add(0, BR,   0, 1, 4'd0, 1, 0, 0, 2);
        add(0, BR,   1, 1, 4'd1, 0, 0, 0, 2);   // BRANCH, zero=1: not taken
        add(0, BR,   1, 1, 4'd9, 0, 0, 0, 2);
        add(0, BR,   1, 1, 4'd0, 1, 0, 0, 3);
        add(0, OP,   1, 1, 4'd1, 0, 0, 0, 3);   // OP: 0,1,6,7,0
        add(0, OP,   1, 1, 4'd6, 0, 0, 0, 3);
        add(0, OP,   1, 1, 4'd7, 0, 0, 0, 3);
        add(0, OP,   1, 1, 4'd0, 1, 0, 0, 4);
        add(0, SW,   1, 1, 4'd1, 0, 0, 0, 4);   // SW latched, then switched to LW
        add(0, SW,   1, 1, 4'd2, 0, 0, 0, 4);
        add(0, LW,   1, 1, 4'd5, 0, 0, 0, 4);
        add(0, LW,   1, 1, 4'd0, 1, 0, 0, 5);
        add(0, LW,   1, 1, 4'd1, 0, 0, 0, 5);   // LW: 0,1,2,3,4,0
        add(0, LW,   1, 1, 4'd2, 0, 0, 0, 5);
        add(0, LW,   1, 1, 4'd3, 0, 0, 0, 5);
        add(0, LW,   1, 1, 4'd4, 0, 0, 0, 5);
        add(0, LW,   1, 1, 4'd0, 1, 0, 0, 6);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].op, vecs[i].z, vecs[i].mr);
            check($sformatf("v%0d curr_state", i),   {28'd0, curr_state}, {28'd0, vecs[i].st});
            check($sformatf("v%0d instr_done", i),   {31'd0, instr_done}, {31'd0, vecs[i].dn});
            check($sformatf("v%0d branch_taken", i), {31'd0, branch_taken}, {31'd0, vecs[i].tk});
            check($sformatf("v%0d halted", i),       {31'd0, halted}, {31'd0, vecs[i].hl});
            check($sformatf("v%0d retired", i),      retired, vecs[i].ret);
        end

        // Illegal opcode: HALT is absorbing until reset.
        step(1, 7'd0, 1, 1);
        step(0, BAD, 1, 1);
        check("halt decode", {28'd0, curr_state}, 32'd1);
        step(0, BAD, 1, 1);
        check("halt enter", {28'd0, curr_state}, 32'd10);
        check("halt flag", {31'd0, halted}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            step(0, OPI, 1, 1);
            check($sformatf("halt hold %0d", i), {28'd0, curr_state}, 32'd10);
        end
        check("halt hold flag", {31'd0, halted}, 32'd1);
        check("halt no retire", retired, 32'd0);
        step(1, OPI, 1, 1);
        check("halt reset state", {28'd0, curr_state}, 32'd0);
        check("halt reset flag", {31'd0, halted}, 32'd0);

        // Reset in MEM_WB aborts the load without a retire or pulse.
        step(0, LW, 1, 1);
        step(0, LW, 1, 1);
        step(0, LW, 1, 1);
        step(0, LW, 1, 1);
        check("abort in MEM_WB", {28'd0, curr_state}, 32'd4);
        step(1, LW, 1, 1);
        check("abort state", {28'd0, curr_state}, 32'd0);
        check("abort done", {31'd0, instr_done}, 32'd0);
        check("abort retired", retired, 32'd0);
        step(0, LW, 1, 1);
        check("abort done later", {31'd0, instr_done}, 32'd0);
        check("abort state later", {28'd0, curr_state}, 32'd1);

        // Memory handshake behaviour for a load.
        step(1, LW, 1, 1);
        pulses = 0;
`ifdef MEM_WAIT_EN
        step(0, LW, 1, 0);
        check("wait fetch hold", {28'd0, curr_state}, 32'd0);
        step(0, LW, 1, 1); check("wait s1", {28'd0, curr_state}, 32'd1);
        step(0, LW, 1, 1); check("wait s2", {28'd0, curr_state}, 32'd2);
        step(0, LW, 1, 1); check("wait s3", {28'd0, curr_state}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            step(0, LW, 1, 0);
            pulses += instr_done;
            check($sformatf("wait read hold %0d", i), {28'd0, curr_state}, 32'd3);
        end
        step(0, LW, 1, 1); pulses += instr_done;
        check("wait s4", {28'd0, curr_state}, 32'd4);
        step(0, LW, 1, 1); pulses += instr_done;
        check("wait s0", {28'd0, curr_state}, 32'd0);
`else
        step(0, LW, 1, 0); check("nowait s1", {28'd0, curr_state}, 32'd1);
        step(0, LW, 1, 0); check("nowait s2", {28'd0, curr_state}, 32'd2);
        step(0, LW, 1, 0); check("nowait s3", {28'd0, curr_state}, 32'd3);
        step(0, LW, 1, 0); pulses += instr_done;
        check("nowait s4", {28'd0, curr_state}, 32'd4);
        step(0, LW, 1, 0); pulses += instr_done;
        check("nowait s0", {28'd0, curr_state}, 32'd0);
`endif
        check("load pulses", pulses, 32'd1);
        check("load retired", retired, 32'd1);

        // Retire counter wrap from 0xFFFFFFFF.
        step(1, OP, 1, 1);
        step(0, OP, 1, 1);
        step(0, OP, 1, 1);
        check("wrap in EXECUTE_R", {28'd0, curr_state}, 32'd6);
        force dut.retired_q = 32'hFFFF_FFFF;
        step(0, OP, 1, 1);
        release dut.retired_q;
        check("wrap in ALU_WB", {28'd0, curr_state}, 32'd7);
        check("wrap preload", retired, 32'hFFFF_FFFF);
        step(0, OP, 1, 1);
        check("wrap retired", retired, 32'd0);
        check("wrap done", {31'd0, instr_done}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Reset is synchronous and active-high; the design has one clock.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  7  instr[6:0] from the instruction register; valid from the DECODE cycle onward.
REQ-005 zero  input  1  ALU zero flag; sampled only in the BNEZ state.
REQ-006 mem_ready  input  1  memory handshake: access completes in the cycle mem_ready=1.
REQ-007 curr_state  output  4  registered state code consumed by the control decoder.
REQ-008 branch_taken  output  1  combinational; high in BNEZ when zero=0.
REQ-009 instr_done  output  1  registered; one-cycle pulse per retired instruction.
REQ-010 halted  output  1  registered; high while in HALT.
REQ-011 retired  output  32  registered count of retired instructions.

Function
REQ-012 State codes: FETCH=0, DECODE=1, MEM_ADR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE_R=6, ALU_WB=7, EXECUTE_I=8, BNEZ=9, HALT=10.
REQ-013 Recognised opcodes: LW=0000011, SW=0100011, OP=0110011, OP_IMM=0010011, BRANCH=1100011.
REQ-014 FETCH -> DECODE.
REQ-015 DECODE: LW/SW -> MEM_ADR; OP -> EXECUTE_R; OP_IMM -> EXECUTE_I; BRANCH -> BNEZ; any other opcode -> HALT.
REQ-016 The opcode is latched into an internal register in DECODE; later decisions use the latched value only, so opcode changes after DECODE have no effect.
REQ-017 MEM_ADR: latched LW -> MEM_READ; latched SW -> MEM_WRITE.
REQ-018 MEM_READ -> MEM_WB; MEM_WB, MEM_WRITE, ALU_WB, BNEZ -> FETCH; EXECUTE_R, EXECUTE_I -> ALU_WB.
REQ-019 HALT is absorbing; only reset leaves it.
REQ-020 Unused codes 11-15 -> HALT on the next edge.
REQ-021 instr_done = 1 in the cycle after a transition from MEM_WB, MEM_WRITE, ALU_WB or BNEZ into FETCH; 0 otherwise.
REQ-022 retired increments by 1 on each such transition; it wraps from 0xFFFFFFFF to 0 with no flag.
REQ-023 Instruction latency without waits: LW 5 cycles; SW, OP, OP_IMM 4 cycles; BRANCH 3 cycles (FETCH to next FETCH).
REQ-024 branch_taken = (curr_state==BNEZ) && !zero; it is 0 in every other state.

Reset
REQ-025 In a reset cycle, reset has priority over every transition and wait.
REQ-026 After reset: curr_state=FETCH, instr_done=0, halted=0, retired=0, latched opcode=0.
REQ-027 Reset asserted mid-instruction or in HALT aborts the instruction with no retire count and no instr_done pulse.

Configuration
REQ-028 Macro MEM_WAIT_EN defined: FETCH, MEM_READ and MEM_WRITE hold their state while mem_ready=0 and advance on the first edge with mem_ready=1.
REQ-029 Waiting never produces an instr_done pulse.
REQ-030 Macro MEM_WAIT_EN undefined: mem_ready is ignored and every memory state lasts exactly one cycle.

Structure
REQ-031 A shared package holds the 4-bit state-code constants (shared with the control decoder) and the 7-bit opcode constants.
REQ-032 One sub-module, opcode_class, maps a 7-bit opcode to a one-hot class {load, store, op, op_imm, branch, illegal}; it is purely combinational.
REQ-033 All other logic is in control_fsm: the state register, next-state logic, opcode latch, counter and pulse.

Verification
REQ-034 Reset, then an OP_IMM instruction with mem_ready=1: curr_state sequence 0,1,8,7,0; instr_done high for one cycle; retired=1.
REQ-035 LW with MEM_WAIT_EN defined and mem_ready low for 3 cycles in MEM_READ: sequence 0,1,2,3,3,3,3,4,0; exactly one instr_done pulse.
REQ-036 BRANCH with zero=0 in BNEZ: branch_taken=1 for one cycle; with zero=1: branch_taken=0; in both cases the next state is FETCH.
REQ-037 Opcode 1111111 in DECODE: HALT (10) entered; halted=1; the state stays 10 for 20 cycles; reset returns curr_state to 0 and halted to 0.
REQ-038 Opcode switched from SW to LW during MEM_ADR: MEM_WRITE (5) is taken.
REQ-039 retired preloaded to 0xFFFFFFFF, then one ALU_WB retire: retired=0.
REQ-040 Reset asserted in MEM_WB: curr_state=0 next cycle; retired unchanged from its reset value 0; no instr_done pulse.
